// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises and filters the raw lines, deframes
// 11-bit frames and turns E0/F0-prefixed scancodes into make/break strobes.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a start bit (falling edge with data low)
// DATA   | shifting in the 8 data bits, LSB first
// PARITY | waiting for the odd-parity bit
// STOP   | waiting for the stop bit; frame is checked on its edge
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] ps2_key_data,
  output logic       ps2_key_pressed,
  output logic       ps2_key_extended,
  output logic       ps2_key_released,
  output logic [7:0] ps2_out,
  output logic       frame_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t state, state_next;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk, filt_clk_d;
  logic [FW-1:0] fcnt;
  logic          fe;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          ext_pending, brk_pending;
  logic          shift_en, par_en, stop_en, timeout_hit;
  logic          frame_ok;

  // Both lines idle high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
      fcnt       <= '0;
    end else begin
      clk_s1     <= ps2_clk;
      clk_s2     <= clk_s1;
      dat_s1     <= ps2_dat;
      dat_s2     <= dat_s1;
      filt_clk_d <= filt_clk;
      if (clk_s2 == filt_clk) begin
        fcnt <= '0;
      end else if (fcnt == FMAX) begin
        filt_clk <= clk_s2;
        fcnt     <= '0;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end
  end

  assign fe = filt_clk_d & ~filt_clk;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    shift_en    = 1'b0;
    par_en      = 1'b0;
    stop_en     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE:   if (fe && !dat_s2) state_next = DATA;
      DATA:   if (fe) begin
                shift_en = 1'b1;
                if (bitcnt == 3'd7) state_next = PARITY;
              end
      PARITY: if (fe) begin
                par_en     = 1'b1;
                state_next = STOP;
              end
      STOP:   if (fe) begin
                stop_en    = 1'b1;
                state_next = IDLE;
              end
      default: state_next = IDLE;
    endcase
    // A falling edge in the same cycle as the terminal count takes priority.
    if (state != IDLE && !fe && tcnt == TMAX) begin
      timeout_hit = 1'b1;
      state_next  = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bitcnt  <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tcnt    <= '0;
    end else begin
      if (state == IDLE) bitcnt <= '0;
      else if (shift_en) bitcnt <= bitcnt + 3'd1;
      if (shift_en) shreg[bitcnt] <= dat_s2;
      if (par_en)   par_bit <= dat_s2;
      if (state == IDLE || fe || timeout_hit) tcnt <= '0;
      else                                    tcnt <= tcnt + TW'(1);
    end
  end

  assign frame_ok = (^shreg ^ par_bit) & dat_s2;

  always_ff @(posedge clock) begin
    if (reset) begin
      ps2_key_data     <= '0;
      ps2_key_pressed  <= 1'b0;
      ps2_key_extended <= 1'b0;
      ps2_key_released <= 1'b0;
      ps2_out          <= '0;
      frame_err        <= 1'b0;
      ext_pending      <= 1'b0;
      brk_pending      <= 1'b0;
    end else begin
      ps2_key_pressed  <= 1'b0;
      ps2_key_released <= 1'b0;
      frame_err        <= timeout_hit;
      if (stop_en) begin
        if (!frame_ok) begin
          frame_err <= 1'b1;
        end else begin
          ps2_out <= shreg;
          if (shreg == 8'hE0) begin
            ext_pending <= 1'b1;
          end else if (shreg == 8'hF0) begin
            brk_pending <= 1'b1;
          end else if (brk_pending) begin
            ps2_key_released <= 1'b1;
            brk_pending      <= 1'b0;
            ext_pending      <= 1'b0;
          end else begin
            ps2_key_data     <= shreg;
            ps2_key_extended <= ext_pending;
            ps2_key_pressed  <= 1'b1;
            ext_pending      <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: a keyboard-side frame driver feeds a scoreboard
// of expected strobes that an independent monitor checks at every output pulse.
module tb_ps2_scancode_rx;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int H              = 20;
  localparam int K_PRESS = 0, K_REL = 1, K_ERR = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed;
  logic       ps2_key_extended;
  logic       ps2_key_released;
  logic [7:0] ps2_out;
  logic       frame_err;

  ps2_scancode_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .ps2_key_data(ps2_key_data), .ps2_key_pressed(ps2_key_pressed),
    .ps2_key_extended(ps2_key_extended), .ps2_key_released(ps2_key_released),
    .ps2_out(ps2_out), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       ext;
    logic [7:0] out;
    bit         lat;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int stop_pin_cyc = 0;

  // Reference model state: what the keyboard session should have produced so far.
  logic [7:0] m_out = 8'h00;
  logic [7:0] m_key = 8'h00;
  logic       m_key_ext = 1'b0;
  bit         m_ext = 0;
  bit         m_brk = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drives the first nbits of an 11-bit frame, optionally glitching ps2_clk
  // low for glen cycles during the high phase of bit gbit.
  task automatic drive_bits(input logic [10:0] bits, input int nbits,
                            input int gbit, input int glen);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      if (i == gbit) begin
        wait_cyc(H / 2);
        ps2_clk = 1'b0;
        wait_cyc(glen);
        ps2_clk = 1'b1;
        wait_cyc(H - H / 2);
      end else begin
        wait_cyc(H);
      end
      ps2_clk = 1'b0;
      if (i == 10) stop_pin_cyc = cyc;
      wait_cyc(H);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit bad_stop, input int gbit, input int glen);
    logic [10:0] bits;
    exp_t e;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    e.lat = 1;
    if (bad_par || bad_stop) begin
      e.kind = K_ERR; e.data = m_key; e.ext = m_key_ext; e.out = m_out;
      q.push_back(e);
    end else begin
      m_out = b;
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (m_brk) begin
        e.kind = K_REL; e.data = m_key; e.ext = m_key_ext; e.out = b;
        q.push_back(e);
        m_brk = 0;
        m_ext = 0;
      end else begin
        m_key = b;
        m_key_ext = m_ext;
        e.kind = K_PRESS; e.data = b; e.ext = m_ext; e.out = b;
        q.push_back(e);
        m_ext = 0;
      end
    end
    drive_bits(bits, 11, gbit, glen);
    wait_cyc(3 * H);
    chk("ps2_out_after_frame", int'(ps2_out), int'(m_out));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_key_data"}, int'(ps2_key_data), 0);
    chk({tag, "_pressed"}, int'(ps2_key_pressed), 0);
    chk({tag, "_extended"}, int'(ps2_key_extended), 0);
    chk({tag, "_released"}, int'(ps2_key_released), 0);
    chk({tag, "_ps2_out"}, int'(ps2_out), 0);
    chk({tag, "_frame_err"}, int'(frame_err), 0);
  endtask

  // Monitor: every output pulse must match the oldest scoreboard entry.
  always @(negedge clock) begin
    if (!reset && (ps2_key_pressed || ps2_key_released || frame_err)) begin
      exp_t e;
      int kind;
      chk("press_release_exclusive", int'(ps2_key_pressed & ps2_key_released), 0);
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: got pressed=%0b released=%0b err=%0b expected none (cycle %0d)",
                 ps2_key_pressed, ps2_key_released, frame_err, cyc);
      end else begin
        e = q.pop_front();
        kind = ps2_key_pressed ? K_PRESS : (ps2_key_released ? K_REL : K_ERR);
        chk("strobe_kind", kind, e.kind);
        chk("strobe_ps2_out", int'(ps2_out), int'(e.out));
        chk("strobe_key_data", int'(ps2_key_data), int'(e.data));
        chk("strobe_extended", int'(ps2_key_extended), int'(e.ext));
        if (e.lat) chk("pin_to_strobe_latency", cyc - stop_pin_cyc, FILTER_LEN + 3);
      end
    end
  end

  initial begin
    wait_cyc(200000);
    $display("FAIL watchdog: got no finish expected finish within 200000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int r;
    reset = 1'b1;
    wait_cyc(4);
    check_all_zero("reset");
    reset = 1'b0;
    wait_cyc(10);

    send_frame(8'h1C, 0, 0, -1, 0);
    send_frame(8'hF0, 0, 0, -1, 0);
    send_frame(8'h1C, 0, 0, -1, 0);
    send_frame(8'hE0, 0, 0, -1, 0);
    send_frame(8'h74, 0, 0, -1, 0);
    send_frame(8'hE0, 0, 0, -1, 0);
    send_frame(8'hF0, 0, 0, -1, 0);
    send_frame(8'h74, 0, 0, -1, 0);
    send_frame(8'h1C, 0, 0, -1, 0);
    send_frame(8'h16, 1, 0, -1, 0);
    send_frame(8'h16, 0, 1, -1, 0);

    begin : timeout_case
      exp_t e;
      e.kind = K_ERR; e.data = m_key; e.ext = m_key_ext; e.out = m_out; e.lat = 0;
      q.push_back(e);
      drive_bits({2'b11, 8'h2D, 1'b0}, 4, -1, 0);
      wait_cyc(TIMEOUT_CYCLES + 100);
      chk("timeout_queue_drained", q.size(), 0);
      chk("timeout_ps2_out", int'(ps2_out), int'(m_out));
    end
    send_frame(8'h2D, 0, 0, -1, 0);

    send_frame(8'h5A, 0, 0, 3, FILTER_LEN - 2);
    send_frame(8'hA5, 0, 0, 8, 2);

    drive_bits({2'b11, 8'h33, 1'b0}, 5, -1, 0);
    ps2_clk = 1'b0;
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(2);
    check_all_zero("midframe_reset");
    ps2_clk = 1'b1;
    reset = 1'b0;
    m_out = 8'h00; m_key = 8'h00; m_key_ext = 1'b0; m_ext = 0; m_brk = 0;
    wait_cyc(3 * H);
    chk("midframe_reset_no_strobe", q.size(), 0);
    send_frame(8'h1C, 0, 0, -1, 0);

    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 20)      b = 8'hE0;
      else if (r < 40) b = 8'hF0;
      else begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hE0 || b == 8'hF0) b = 8'h29;
      end
      r = int'($urandom_range(0, 99));
      send_frame(b, r < 8, (r >= 8 && r < 13),
                 (r >= 50) ? int'($urandom_range(0, 10)) : -1,
                 int'($urandom_range(1, FILTER_LEN - 2)));
    end

    wait_cyc(2 * H);
    chk("scoreboard_empty_at_end", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
